// File: rtl/hub_bcast_writer_pkg.sv
// -----------------------------------------------------------------------------
// hub_bcast_writer_pkg
// Shared constants and helpers for the hub broadcast read writer:
//   - hub address space selector and per-board block size
//   - state encoding of the writer FSM
//   - helpers that build the hub write address and the header quadlet
// No ports (package).
// -----------------------------------------------------------------------------
package hub_bcast_writer_pkg;

    // Upper nibble of every hub memory write address
    localparam logic [3:0] ADDR_HUB        = 4'h1;
    // Quadlets reserved per board in hub memory
    localparam int         HUB_BLOCK_QUADS = 32;
    // Width of a quadlet index within a board block
    localparam int         QUAD_W          = $clog2(HUB_BLOCK_QUADS);
    // Header quadlet layout: {sequence[15:0], zero pad, board_id[3:0]}
    localparam int         HDR_SEQ_W       = 16;
    localparam int         HDR_BID_W       = 4;
    localparam int         HDR_PAD_W       = 32 - HDR_SEQ_W - HDR_BID_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNT    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_SEND_HDR = 3'd3,
        ST_FETCH    = 3'd4,
        ST_SEND     = 3'd5,
        ST_PEND     = 3'd6
    } state_e;

    // Hub write address: {ADDR_HUB, 3'b000, board_id, quad}
    function automatic logic [15:0] hub_addr(input logic [HDR_BID_W-1:0] bid,
                                             input logic [QUAD_W-1:0]    quad);
        return {ADDR_HUB, 3'b000, bid, quad};
    endfunction

    // Header quadlet carrying the broadcast sequence and the sender's id
    function automatic logic [31:0] hdr_quad(input logic [HDR_SEQ_W-1:0] seq,
                                             input logic [HDR_BID_W-1:0] bid);
        return {seq, {HDR_PAD_W{1'b0}}, bid};
    endfunction

    // Saturating 8-bit increment
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

endpackage

// File: rtl/hub_bcast_writer_if.sv
// -----------------------------------------------------------------------------
// hub_bcast_writer_if
// Write-request stream from the broadcast writer to the packet transmitter.
//   tx_valid  write request valid (writer -> transmitter)
//   tx_ready  transmitter accepts   (transmitter -> writer)
//   tx_addr   16-bit hub quadlet address
//   tx_data   32-bit quadlet payload
//   tx_last   final quadlet of the board block
// Modports: master = writer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface hub_bcast_writer_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_addr;
    logic [31:0] tx_data;
    logic        tx_last;

    modport master (output tx_valid, output tx_addr, output tx_data,
                    output tx_last,  input  tx_ready);
    modport slave  (input  tx_valid, input  tx_addr, input  tx_data,
                    input  tx_last,  output tx_ready);
endinterface

// File: rtl/hub_bcast_writer.sv
// -----------------------------------------------------------------------------
// hub_bcast_writer
// Board-side responder to a hub broadcast read. On a request whose mask
// includes this board, it ranks the board among the set mask bits (serially,
// one bit per cycle), waits rank*SLOT_CYCLES cycles, then writes a header
// quadlet and NUM_QUADS-1 status quadlets into this board's hub region.
// Ports:
//   sysclk, reset      clock, synchronous active-high reset
//   board_id           this board's number (sampled with bcast_req)
//   bcast_req          one-cycle broadcast request strobe
//   bcast_data         {sequence[31:16], board_mask[15:0]}
//   src_addr/src_data  status source; data valid one cycle after address
//   tx                 write-request stream (master modport)
//   busy               high whenever the FSM is not idle
//   missed             saturating count of dropped requests
// -----------------------------------------------------------------------------
module hub_bcast_writer
    import hub_bcast_writer_pkg::*;
#(
    parameter int NUM_QUADS   = 16,
    parameter int SLOT_CYCLES = 800
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic [3:0]                 board_id,
    input  logic                       bcast_req,
    input  logic [31:0]                bcast_data,
    output logic [4:0]                 src_addr,
    input  logic [31:0]                src_data,
    hub_bcast_writer_if.master         tx,
    output logic                       busy,
    output logic [7:0]                 missed
);

    localparam logic [QUAD_W-1:0] LAST_QUAD = QUAD_W'(NUM_QUADS - 1);
    localparam logic [23:0]       SLOT_LEN  = 24'(SLOT_CYCLES);

    state_e             state_r;
    logic [15:0]        seq_r;
    logic [15:0]        mask_r;
    logic [3:0]         bid_r;
    logic [3:0]         rank_r;
    logic [3:0]         bit_r;
    logic [23:0]        wait_r;
    logic [QUAD_W-1:0]  quad_r;
    logic               pend_valid_r;
    logic [15:0]        pend_seq_r;
    logic [15:0]        pend_mask_r;
    logic [3:0]         pend_bid_r;
    logic               tx_valid_r;
    logic               tx_last_r;
    logic [15:0]        tx_addr_r;
    logic [31:0]        data_r;
    logic               pass_r;
    logic [4:0]         src_addr_r;
    logic               busy_r;
    logic [7:0]         missed_r;

    logic               hs_s;
    logic               launch_s;
    logic               missed_inc_s;
    logic [15:0]        req_seq_s;
    logic [15:0]        req_mask_s;
    logic [3:0]         req_bid_s;
    logic               req_own_s;

    // Request selection: a live strobe always wins over the stored pending one
    always_comb begin
        hs_s       = tx_valid_r & tx.tx_ready;
        req_seq_s  = pend_seq_r;
        req_mask_s = pend_mask_r;
        req_bid_s  = pend_bid_r;
        if (bcast_req) begin
            req_seq_s  = bcast_data[31:16];
            req_mask_s = bcast_data[15:0];
            req_bid_s  = board_id;
        end else begin
            req_seq_s  = pend_seq_r;
            req_mask_s = pend_mask_r;
            req_bid_s  = pend_bid_r;
        end
        req_own_s = req_mask_s[req_bid_s];
    end

    // Launch/drop decisions: restart in IDLE/COUNT/WAIT, service stored request in PEND
    always_comb begin
        launch_s     = 1'b0;
        missed_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                launch_s = bcast_req;
            end
            ST_COUNT, ST_WAIT: begin
                launch_s     = bcast_req;
                missed_inc_s = bcast_req;
            end
            ST_PEND: begin
                launch_s     = 1'b1;
                missed_inc_s = bcast_req;
            end
            ST_SEND_HDR, ST_FETCH, ST_SEND: begin
                missed_inc_s = bcast_req & pend_valid_r;
            end
            default: begin
                launch_s     = 1'b0;
                missed_inc_s = 1'b0;
            end
        endcase
    end

    // Writer FSM with registered stream outputs
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            seq_r        <= 16'h0000;
            mask_r       <= 16'h0000;
            bid_r        <= 4'h0;
            rank_r       <= 4'h0;
            bit_r        <= 4'h0;
            wait_r       <= 24'h000000;
            quad_r       <= '0;
            pend_valid_r <= 1'b0;
            pend_seq_r   <= 16'h0000;
            pend_mask_r  <= 16'h0000;
            pend_bid_r   <= 4'h0;
            tx_valid_r   <= 1'b0;
            tx_last_r    <= 1'b0;
            tx_addr_r    <= 16'h0000;
            data_r       <= 32'h0000_0000;
            pass_r       <= 1'b0;
            src_addr_r   <= 5'd0;
            busy_r       <= 1'b0;
            missed_r     <= 8'h00;
        end else begin
            if (missed_inc_s) begin
                missed_r <= sat_inc8(missed_r);
            end

            if (launch_s) begin
                seq_r        <= req_seq_s;
                mask_r       <= req_mask_s;
                bid_r        <= req_bid_s;
                rank_r       <= 4'h0;
                bit_r        <= 4'h0;
                pend_valid_r <= 1'b0;
                busy_r       <= req_own_s;
                state_r      <= req_own_s ? ST_COUNT : ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                    end
                    ST_COUNT: begin
                        // Rank = number of lower-numbered boards present in the mask
                        if ((bit_r < bid_r) && mask_r[bit_r]) begin
                            rank_r <= rank_r + 4'd1;
                        end
                        if (bit_r == 4'd15) begin
                            // Bit 15 can never be below board_id, so rank_r is final here
                            wait_r  <= {20'h00000, rank_r} * SLOT_LEN;
                            state_r <= ST_WAIT;
                        end else begin
                            bit_r <= bit_r + 4'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_r == 24'h000000) begin
                            state_r    <= ST_SEND_HDR;
                            tx_valid_r <= 1'b1;
                            tx_last_r  <= 1'b0;
                            tx_addr_r  <= hub_addr(bid_r, '0);
                            data_r     <= hdr_quad(seq_r, bid_r);
                            quad_r     <= '0;
                        end else begin
                            wait_r <= wait_r - 24'h000001;
                        end
                    end
                    ST_SEND_HDR: begin
                        if (hs_s) begin
                            tx_valid_r <= 1'b0;
                            quad_r     <= QUAD_W'(1);
                            src_addr_r <= 5'd1;
                            state_r    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        tx_valid_r <= 1'b1;
                        tx_addr_r  <= hub_addr(bid_r, quad_r);
                        tx_last_r  <= (quad_r == LAST_QUAD);
                        pass_r     <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                    ST_SEND: begin
                        // First SEND cycle forwards src_data live and captures it for any stall
                        if (pass_r) begin
                            data_r <= src_data;
                            pass_r <= 1'b0;
                        end
                        if (hs_s) begin
                            tx_valid_r <= 1'b0;
                            tx_last_r  <= 1'b0;
                            if (tx_last_r) begin
                                state_r <= (pend_valid_r | bcast_req) ? ST_PEND : ST_IDLE;
                                busy_r  <= pend_valid_r | bcast_req;
                            end else begin
                                quad_r     <= quad_r + QUAD_W'(1);
                                src_addr_r <= 5'(quad_r + QUAD_W'(1));
                                state_r    <= ST_FETCH;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase

                // Requests arriving while streaming are parked (latest one wins)
                if ((state_r == ST_SEND_HDR || state_r == ST_FETCH || state_r == ST_SEND) && bcast_req) begin
                    pend_valid_r <= 1'b1;
                    pend_seq_r   <= bcast_data[31:16];
                    pend_mask_r  <= bcast_data[15:0];
                    pend_bid_r   <= board_id;
                end
            end
        end
    end

    assign tx.tx_valid = tx_valid_r;
    assign tx.tx_last  = tx_last_r;
    assign tx.tx_addr  = tx_addr_r;
    assign tx.tx_data  = pass_r ? src_data : data_r;
    assign src_addr    = src_addr_r;
    assign busy        = busy_r;
    assign missed      = missed_r;

endmodule

// File: tb/tb_hub_bcast_writer.sv
// -----------------------------------------------------------------------------
// tb_hub_bcast_writer
// Directed bench for hub_bcast_writer with default parameters
// (NUM_QUADS=16, SLOT_CYCLES=800). The status source is a registered memory
// returning 32'hC0DE0000 + address one cycle after the address.
// -----------------------------------------------------------------------------
module tb_hub_bcast_writer;

    logic        sysclk;
    logic        reset;
    logic [3:0]  board_id;
    logic        bcast_req;
    logic [31:0] bcast_data;
    logic [4:0]  src_addr;
    logic [31:0] src_data;
    logic        busy;
    logic [7:0]  missed;

    int n_checks;
    int n_fail;

    hub_bcast_writer_if txb();

    hub_bcast_writer #(.NUM_QUADS(16), .SLOT_CYCLES(800)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .board_id   (board_id),
        .bcast_req  (bcast_req),
        .bcast_data (bcast_data),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .tx         (txb),
        .busy       (busy),
        .missed     (missed)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Status source: one-cycle read latency
    always @(posedge sysclk) src_data <= 32'hC0DE_0000 | {27'd0, src_addr};

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
    endtask

    // Pulse bcast_req in cycle 0; returns at the negedge of cycle 1
    task automatic send_req(input logic [15:0] seq, input logic [15:0] mask, input logic [3:0] bid);
        @(negedge sysclk);
        board_id   = bid;
        bcast_data = {seq, mask};
        bcast_req  = 1'b1;
        @(negedge sysclk);
        bcast_req  = 1'b0;
    endtask

    task automatic wait_valid(input int start, input int max, output int cyc);
        cyc = start;
        while (txb.tx_valid !== 1'b1 && cyc < max) begin
            @(negedge sysclk);
            cyc++;
        end
    endtask

    // Receive one 16-quadlet block; mode 0: ready high, 1: ready 1-in-3,
    // 2: ready high plus two injected requests mid-block
    task automatic collect_block(input logic [15:0] seq, input logic [3:0] bid, input int mode);
        int q, guard, last_hs;
        bit stalled, chk_src;
        logic [15:0] pa, ea;
        logic [31:0] pd, ed;
        logic pl, el;
        q = 0; guard = 0; last_hs = 0; stalled = 0; chk_src = 0;
        pa = 16'h0; pd = 32'h0; pl = 1'b0;
        while (q < 16 && guard < 400) begin
            bcast_req = 1'b0;
            txb.tx_ready = (mode == 1) ? (guard % 3 == 2) : 1'b1;
            if (chk_src) begin
                n_checks++;
                if (src_addr !== q[4:0]) begin
                    n_fail++;
                    $display("FAIL src_addr: got %0d expected %0d", src_addr, q);
                end
                chk_src = 0;
            end
            if (txb.tx_valid === 1'b1) begin
                ea = {4'h1, 3'b000, bid, q[4:0]};
                ed = (q == 0) ? {seq, 12'h000, bid} : (32'hC0DE_0000 + 32'(q));
                el = (q == 15);
                if (stalled) begin
                    n_checks++;
                    if (txb.tx_addr !== pa || txb.tx_data !== pd || txb.tx_last !== pl) begin
                        n_fail++;
                        $display("FAIL stall_stable q=%0d: got %h/%h/%b expected %h/%h/%b",
                                 q, txb.tx_addr, txb.tx_data, txb.tx_last, pa, pd, pl);
                    end
                end
                n_checks++;
                if (txb.tx_addr !== ea) begin
                    n_fail++;
                    $display("FAIL tx_addr q=%0d: got %h expected %h", q, txb.tx_addr, ea);
                end
                n_checks++;
                if (txb.tx_data !== ed) begin
                    n_fail++;
                    $display("FAIL tx_data q=%0d: got %h expected %h", q, txb.tx_data, ed);
                end
                n_checks++;
                if (txb.tx_last !== el) begin
                    n_fail++;
                    $display("FAIL tx_last q=%0d: got %b expected %b", q, txb.tx_last, el);
                end
                if (txb.tx_ready === 1'b1) begin
                    if (mode != 1 && q >= 1) begin
                        n_checks++;
                        if (guard - last_hs !== 2) begin
                            n_fail++;
                            $display("FAIL quad_latency q=%0d: got %0d expected 2", q, guard - last_hs);
                        end
                    end
                    last_hs = guard;
                    q++;
                    stalled = 0;
                    chk_src = (q < 16);
                    if (mode == 2 && (q == 4 || q == 8)) begin
                        bcast_req  = 1'b1;
                        bcast_data = (q == 4) ? {16'h0B0B, 16'h0002} : {16'h0C0C, 16'h0002};
                    end
                end else begin
                    stalled = 1;
                    pa = txb.tx_addr; pd = txb.tx_data; pl = txb.tx_last;
                end
            end else begin
                n_checks++;
                if (stalled !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_drop q=%0d: tx_valid got 0 expected 1", q);
                end
            end
            if (q < 16) begin
                @(negedge sysclk);
                guard++;
            end
        end
        bcast_req = 1'b0;
        n_checks++;
        if (q !== 16) begin
            n_fail++;
            $display("FAIL block_count: got %0d quadlets expected 16", q);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({txb.tx_valid, txb.tx_last, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {txb.tx_valid, txb.tx_last, busy});
        end
        n_checks++;
        if (txb.tx_addr !== 16'h0000 || txb.tx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h expected 0000/00000000", txb.tx_addr, txb.tx_data);
        end
        n_checks++;
        if (src_addr !== 5'd0 || missed !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_src_missed: got %0d/%0d expected 0/0", src_addr, missed);
        end
    endtask

    task automatic test_rank2(input logic [15:0] seq);
        int cyc;
        send_req(seq, 16'h00A5, 4'd5);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: got %b expected 1", busy);
        end
        wait_valid(1, 3000, cyc);
        n_checks++;
        if (cyc !== 1618) begin
            n_fail++;
            $display("FAIL rank2_first_valid: got %0d expected 1618", cyc);
        end
        collect_block(seq, 4'd5, 0);
        @(negedge sysclk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: got %b expected 0", busy);
        end
    endtask

    task automatic test_rank0();
        int cyc;
        send_req(16'h0101, 16'h0002, 4'd1);
        wait_valid(1, 200, cyc);
        n_checks++;
        if (cyc !== 18) begin
            n_fail++;
            $display("FAIL rank0_first_valid: got %0d expected 18", cyc);
        end
        collect_block(16'h0101, 4'd1, 0);
    endtask

    task automatic test_not_own();
        bit seen;
        seen = 0;
        send_req(16'h0202, 16'h0001, 4'd3);
        repeat (40) begin
            if (txb.tx_valid !== 1'b0 || busy !== 1'b0) seen = 1;
            @(negedge sysclk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL not_own: activity got 1 expected 0");
        end
    endtask

    task automatic test_stall();
        int cyc;
        send_req(16'h5A5A, 16'h0002, 4'd1);
        wait_valid(1, 200, cyc);
        n_checks++;
        if (cyc !== 18) begin
            n_fail++;
            $display("FAIL stall_first_valid: got %0d expected 18", cyc);
        end
        collect_block(16'h5A5A, 4'd1, 1);
        txb.tx_ready = 1'b1;
    endtask

    task automatic test_wait_abort();
        int cyc;
        bit seen;
        seen = 0;
        send_req(16'h1111, 16'h00A5, 4'd5);
        repeat (100) begin
            if (txb.tx_valid !== 1'b0) seen = 1;
            @(negedge sysclk);
        end
        send_req(16'h1234, 16'h00A5, 4'd5);
        wait_valid(1, 3000, cyc);
        n_checks++;
        if (cyc !== 1618 || seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_first_valid: got %0d (early %b) expected 1618 (early 0)", cyc, seen);
        end
        collect_block(16'h1234, 4'd5, 0);
        n_checks++;
        if (missed !== 8'd1) begin
            n_fail++;
            $display("FAIL abort_missed: got %0d expected 1", missed);
        end
    endtask

    task automatic test_pending();
        int cyc;
        bit seen;
        seen = 0;
        do_reset();
        send_req(16'h0A0A, 16'h0002, 4'd1);
        wait_valid(1, 200, cyc);
        collect_block(16'h0A0A, 4'd1, 2);
        @(negedge sysclk);
        wait_valid(1, 200, cyc);
        n_checks++;
        if (cyc !== 19) begin
            n_fail++;
            $display("FAIL pend_latency: got %0d expected 19", cyc);
        end
        collect_block(16'h0C0C, 4'd1, 0);
        n_checks++;
        if (missed !== 8'd1) begin
            n_fail++;
            $display("FAIL pend_missed: got %0d expected 1", missed);
        end
        @(negedge sysclk);
        repeat (40) begin
            if (txb.tx_valid !== 1'b0 || busy !== 1'b0) seen = 1;
            @(negedge sysclk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_extra_block: activity got 1 expected 0");
        end
    endtask

    task automatic test_reset_mid();
        int cyc, n;
        send_req(16'h3333, 16'h0002, 4'd1);
        wait_valid(1, 200, cyc);
        txb.tx_ready = 1'b1;
        repeat (5) @(negedge sysclk);
        txb.tx_ready = 1'b0;
        n = 0;
        while (txb.tx_valid !== 1'b1 && n < 10) begin
            @(negedge sysclk);
            n++;
        end
        n_checks++;
        if (txb.tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_send_valid: got %b expected 1", txb.tx_valid);
        end
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        n_checks++;
        if (txb.tx_valid !== 1'b0 || busy !== 1'b0 || missed !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b busy=%b missed=%0d expected 0/0/0",
                     txb.tx_valid, busy, missed);
        end
        txb.tx_ready = 1'b1;
        test_rank2(16'h7777);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        board_id     = 4'd0;
        bcast_req    = 1'b0;
        bcast_data   = 32'h0;
        txb.tx_ready = 1'b1;
        test_reset();
        test_rank2(16'hBEEF);
        test_rank0();
        test_not_own();
        test_stall();
        test_wait_abort();
        test_pending();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
